// File: rtl/tagged_flux_fifo_pkg.sv
// Shared types and helpers for the tagged multi-flux FIFO.
package flux_pkg;

  localparam int DEF_FLUX       = 2;
  localparam int DEF_DATA_WIDTH = 27;
  localparam int DEF_DEPTH      = 16;

  // At least one tag bit, even for degenerate flux counts.
  function automatic int tag_width(input int flux);
    return (flux <= 2) ? 1 : $clog2(flux);
  endfunction

  localparam int DEF_TAG_WIDTH = tag_width(DEF_FLUX);
  localparam int DEF_PTR_WIDTH = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] payload;
  } tagged_word_t;

  typedef struct packed {
    logic [DEF_PTR_WIDTH-1:0] wr_ptr;
    logic [DEF_PTR_WIDTH-1:0] rd_ptr;
    logic [DEF_PTR_WIDTH:0]   count;
  } flux_state_t;

endpackage

// File: rtl/tagged_flux_fifo_queue.sv
// Single-flux circular buffer; a write to a full queue lands only alongside a same-cycle pop.
module flux_queue #(
  parameter int DATA_WIDTH = 27,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
  } state_t;

  state_t                r_st;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= '0;
    end else begin
      if (w_push) r_st.wr_ptr <= r_st.wr_ptr + 1'b1;
      if (w_pop)  r_st.rd_ptr <= r_st.rd_ptr + 1'b1;
      r_st.count <= r_st.count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_st.wr_ptr] <= din;
  end

  assign head  = r_mem[r_st.rd_ptr];
  assign empty = (r_st.count == '0);
  assign full  = (r_st.count == (PW+1)'(DEPTH));

endmodule

// File: rtl/tagged_flux_fifo.sv
// Tagged multi-flux FIFO: demuxes {tag,data} writes into FLUX queues and re-tags the selected head.
// Optional sticky error flags are built when TAGGED_FIFO_ERR_EN is defined.
module tagged_flux_fifo
  import flux_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 27,
  parameter int DEPTH      = 16,
  parameter int TAG_WIDTH  = tag_width(FLUX)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] din,
  input  logic                          write,
  output logic [FLUX-1:0]               full,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] dout,
  input  logic [FLUX-1:0]               read,
  output logic [FLUX-1:0]               empty
`ifdef TAGGED_FIFO_ERR_EN
  ,
  output logic [FLUX-1:0]               overflow_err,
  output logic [FLUX-1:0]               underflow_err,
  output logic                          multi_read_err
`endif
);

  localparam int DW = TAG_WIDTH + DATA_WIDTH;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [FLUX-1:0]       w_wr_en;
  logic [FLUX-1:0]       w_rd_en;
  logic [TAG_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0] w_head [FLUX];
  logic [DATA_WIDTH-1:0] w_head_sel;

  assign w_tag     = din[DW-1 -: TAG_WIDTH];
  assign w_payload = din[DATA_WIDTH-1:0];

  // Tags with no matching flux select nothing, so such writes drop out here.
  always_comb begin
    w_wr_en = '0;
    for (int f = 0; f < FLUX; f++) begin
      w_wr_en[f] = write && (w_tag == TAG_WIDTH'(f));
    end
  end

  // Lowest read wins; otherwise lowest non-empty; otherwise flux 0.
  always_comb begin
    w_sel = '0;
    for (int f = FLUX-1; f >= 0; f--) begin
      if (!empty[f]) w_sel = TAG_WIDTH'(f);
    end
    if (|read) begin
      for (int f = FLUX-1; f >= 0; f--) begin
        if (read[f]) w_sel = TAG_WIDTH'(f);
      end
    end
  end

  always_comb begin
    w_rd_en    = '0;
    w_head_sel = '0;
    for (int f = 0; f < FLUX; f++) begin
      w_rd_en[f] = read[f] && (w_sel == TAG_WIDTH'(f));
      if (w_sel == TAG_WIDTH'(f)) w_head_sel = w_head[f];
    end
  end

  assign dout = {w_sel, w_head_sel};

  for (genvar g = 0; g < FLUX; g++) begin : g_queue
    flux_queue #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_queue (
      .clk  (clk),
      .rst  (rst),
      .wr_en(w_wr_en[g]),
      .rd_en(w_rd_en[g]),
      .din  (w_payload),
      .head (w_head[g]),
      .empty(empty[g]),
      .full (full[g])
    );
  end

`ifdef TAGGED_FIFO_ERR_EN
  logic [FLUX-1:0] w_ovf_set;
  logic [FLUX-1:0] w_udf_set;
  logic            w_mre_set;
  logic            w_tag_ok;
  logic [FLUX-1:0] r_ovf;
  logic [FLUX-1:0] r_udf;
  logic            r_mre;

  always_comb begin
    w_tag_ok  = 1'b0;
    w_ovf_set = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (w_tag == TAG_WIDTH'(f)) w_tag_ok = 1'b1;
      w_ovf_set[f] = w_wr_en[f] && full[f] && !(w_rd_en[f] && !empty[f]);
    end
    w_ovf_set[0] = w_ovf_set[0] || (write && !w_tag_ok);
  end

  assign w_udf_set = read & empty;
  assign w_mre_set = ((read & (read - 1'b1)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_udf <= '0;
      r_mre <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_ovf_set;
      r_udf <= r_udf | w_udf_set;
      r_mre <= r_mre | w_mre_set;
    end
  end

  assign overflow_err   = r_ovf;
  assign underflow_err  = r_udf;
  assign multi_read_err = r_mre;
`endif

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Self-checking bench for tagged_flux_fifo: queue-based reference model plus directed literal checks.
// Error-flag checks are compiled in when TAGGED_FIFO_ERR_EN is defined.
module tb_tagged_flux_fifo;
  import flux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] din;
  logic        write;
  logic [1:0]  read;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [27:0] dout;

  logic [9:0]  din3;
  logic        write3;
  logic [2:0]  read3;
  logic [2:0]  full3;
  logic [2:0]  empty3;
  logic [9:0]  dout3;

`ifdef TAGGED_FIFO_ERR_EN
  logic [1:0]  ovf_err, udf_err;
  logic        mre_err;
  logic [2:0]  ovf_err3, udf_err3;
  logic        mre_err3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [26:0] mq [2][$];

  always #5 clk = ~clk;

  tagged_flux_fifo #(.FLUX(2), .DATA_WIDTH(27), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
    .dout(dout), .read(read), .empty(empty)
`ifdef TAGGED_FIFO_ERR_EN
    , .overflow_err(ovf_err), .underflow_err(udf_err), .multi_read_err(mre_err)
`endif
  );

  // Three fluxes leave tag value 3 unused, which exercises the bad-tag drop.
  tagged_flux_fifo #(.FLUX(3), .DATA_WIDTH(8), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .write(write3), .full(full3),
    .dout(dout3), .read(read3), .empty(empty3)
`ifdef TAGGED_FIFO_ERR_EN
    , .overflow_err(ovf_err3), .underflow_err(udf_err3), .multi_read_err(mre_err3)
`endif
  );

  function automatic logic [27:0] mk(input int tag, input int payload);
    tagged_word_t w;
    w.tag     = tag[0];
    w.payload = payload[26:0];
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int s;
    s = 0;
    if (read[0])                 s = 0;
    else if (read[1])            s = 1;
    else if (mq[0].size() != 0)  s = 0;
    else if (mq[1].size() != 0)  s = 1;
    chk("empty", empty, {mq[1].size() == 0, mq[0].size() == 0});
    chk("full",  full,  {mq[1].size() == 16, mq[0].size() == 16});
    chk("dout_tag", dout[27], s[0]);
    if (mq[s].size() != 0) chk("dout_payload", dout[26:0], mq[s][0]);
  endtask

  task automatic model_update(input logic w, input logic [27:0] d, input logic [1:0] r);
    int rs;
    int t;
    rs = r[0] ? 0 : (r[1] ? 1 : -1);
    if (rs >= 0 && mq[rs].size() != 0) void'(mq[rs].pop_front());
    if (w) begin
      t = int'(d[27]);
      if (mq[t].size() < 16) mq[t].push_back(d[26:0]);
    end
  endtask

  task automatic drive(input logic w, input logic [27:0] d, input logic [1:0] r);
    write = w;
    din   = d;
    read  = r;
    #1;
  endtask

  task automatic step();
    logic       w;
    logic [27:0] d;
    logic [1:0] r;
    w = write; d = din; r = read;
    model_check();
    @(posedge clk);
    model_update(w, d, r);
    @(negedge clk);
  endtask

  task automatic cycle(input logic w, input logic [27:0] d, input logic [1:0] r);
    drive(w, d, r);
    step();
  endtask

  task automatic reset_dut();
    write  = 1'b0;
    read   = 2'b00;
    write3 = 1'b0;
    read3  = 3'b000;
    rst    = 1'b1;
    @(posedge clk);
    mq[0].delete();
    mq[1].delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    din  = '0;
    din3 = '0;
    reset_dut();
    chk("rst_empty", empty, 2'b11);
    chk("rst_full",  full,  2'b00);

    // Fill and drain flux 1
    for (int i = 0; i < 16; i++) cycle(1'b1, mk(1, 'hA5 + i), 2'b00);
    chk("fill_full",  full,  2'b10);
    chk("fill_empty", empty, 2'b01);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 2'b10);
      chk("drain_dout", dout, mk(1, 'hA5 + i));
      step();
    end
    chk("drain_empty", empty, 2'b11);

    // Interleaved fluxes
    cycle(1'b1, mk(0, 'h10), 2'b00);
    cycle(1'b1, mk(1, 'h20), 2'b00);
    cycle(1'b1, mk(0, 'h11), 2'b00);
    drive(1'b0, '0, 2'b00);
    chk("il_empty", empty, 2'b00);
    chk("il_idle_dout", dout, mk(0, 'h10));
    step();
    drive(1'b0, '0, 2'b10);
    chk("il_pop1_dout", dout, mk(1, 'h20));
    step();
    chk("il_flux1_empty", empty, 2'b10);
    cycle(1'b0, '0, 2'b01);
    cycle(1'b0, '0, 2'b01);
    chk("il_all_empty", empty, 2'b11);

    // Simultaneous write and pop at full, then overfill
    for (int i = 0; i < 16; i++) cycle(1'b1, mk(0, 'h100 + i), 2'b00);
    chk("wp_full_before", full, 2'b01);
    drive(1'b1, mk(0, 'h55), 2'b01);
    chk("wp_dout", dout, mk(0, 'h100));
    step();
    chk("wp_full_after", full, 2'b01);
    cycle(1'b1, mk(0, 'h77), 2'b00);
    chk("ovf_full", full, 2'b01);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, '0, 2'b01);
      chk("wp_order", dout, mk(0, 'h101 + i));
      step();
    end
    drive(1'b0, '0, 2'b01);
    chk("wp_55_last", dout, mk(0, 'h55));
    step();
    chk("ovf_dropped", empty, 2'b11);

    // Read on empty flux 1 is ignored
    cycle(1'b0, '0, 2'b10);
    chk("udf_empty", empty, 2'b11);
    cycle(1'b1, mk(1, 'h33), 2'b00);
    drive(1'b0, '0, 2'b10);
    chk("udf_ptr", dout, mk(1, 'h33));
    step();

    // Write and pop the same empty flux together
    cycle(1'b1, mk(0, 'h66), 2'b01);
    chk("wr_empty_pop", empty, 2'b10);
    drive(1'b0, '0, 2'b01);
    chk("wr_empty_dout", dout, mk(0, 'h66));
    step();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(1, 'h200 + i), 2'b00);
    reset_dut();
    chk("mid_rst_empty", empty, 2'b11);
    chk("mid_rst_full",  full,  2'b00);
    cycle(1'b1, mk(1, 'h44), 2'b00);
    drive(1'b0, '0, 2'b10);
    chk("post_rst_dout", dout, mk(1, 'h44));
    step();
    chk("post_rst_empty", empty, 2'b11);

    // Bad tag on the three-flux instance
    din3 = {2'd3, 8'h77};
    write3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write3 = 1'b0;
    #1;
    chk("badtag_empty", empty3, 3'b111);
    chk("badtag_full",  full3,  3'b000);
`ifdef TAGGED_FIFO_ERR_EN
    chk("badtag_ovf", ovf_err3, 3'b001);
`endif
    din3 = {2'd2, 8'h5A};
    write3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write3 = 1'b0;
    #1;
    chk("tag2_empty", empty3, 3'b011);
    chk("tag2_dout",  dout3,  {2'd2, 8'h5A});

`ifdef TAGGED_FIFO_ERR_EN
    reset_dut();
    chk("err_rst", {ovf_err, udf_err, mre_err}, 5'b0);
    cycle(1'b1, mk(0, 1), 2'b00);
    cycle(1'b1, mk(0, 2), 2'b00);
    cycle(1'b1, mk(1, 3), 2'b00);
    chk("mre_before", mre_err, 1'b0);
    cycle(1'b0, '0, 2'b11);
    chk("mre_set", mre_err, 1'b1);
    chk("mre_flux1_kept", empty, 2'b00);
    cycle(1'b0, '0, 2'b10);
    chk("udf_before", udf_err, 2'b00);
    cycle(1'b0, '0, 2'b10);
    chk("udf_set", udf_err, 2'b10);
    cycle(1'b1, mk(1, 4), 2'b00);
    cycle(1'b0, '0, 2'b01);
    chk("udf_held", udf_err, 2'b10);
    reset_dut();
    chk("err_clear", {udf_err, mre_err}, 3'b0);
`endif

    // Randomized traffic alternating fill-heavy and drain-heavy phases
    reset_dut();
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_dut();
      end else begin
        logic        w;
        logic [1:0]  r;
        int          wp;
        int          rp;
        wp = ((it / 100) % 2 == 0) ? 80 : 30;
        rp = ((it / 100) % 2 == 0) ? 25 : 75;
        w  = ($urandom_range(0, 99) < wp);
        r  = ($urandom_range(0, 99) < rp) ? 2'($urandom_range(1, 3)) : 2'b00;
        cycle(w, mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 32'h7FF_FFFF))), r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
